// File: rtl/winograd_f23_conv_if.sv
`default_nettype none
// ============================================================================
// Module      : winograd_f23_conv_if
// Description : Request/capture link between the line buffer and the
//               Winograd F(2,3) convolution stage. The line buffer drives
//               the window and the finish flag; the convolver raises the
//               one-cycle read request.
// Revision    : 1.0 - initial release
// ============================================================================
interface winograd_f23_conv_if #(
  parameter int M = 3
);
  logic [M*32-1:0] i_window;
  logic            o_rd_req;
  logic            i_finish_reading;

  // Line-buffer side
  modport master (output i_window, output i_finish_reading, input o_rd_req);
  // Convolver side
  modport slave  (input i_window, input i_finish_reading, output o_rd_req);
endinterface
`default_nettype wire

// File: rtl/winograd_f23_conv.sv
`default_nettype none
// ============================================================================
// Module      : winograd_f23_conv
// Description : Pulls M-row x 4-column windows from the line buffer, runs a
//               1-D Winograd F(2,3) per row, sums the rows and emits two
//               adjacent output pixels per window (three-stage pipeline).
//               Optional macro WINOGRAD_RELU_EN clamps negative outputs to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module winograd_f23_conv #(
  parameter int M     = 3,
  parameter int W     = 10,
  parameter int ACC_W = 24
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_w_valid,
  input  logic signed [7:0]        i_w_data,
  output logic                     o_w_loaded,
  input  logic                     i_start,
  winograd_f23_conv_if.slave       lb,
  output logic signed [ACC_W-1:0]  o_y0,
  output logic signed [ACC_W-1:0]  o_y1,
  output logic [$clog2(W)-1:0]     o_col,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int COL_W = $clog2(W);
  localparam int NW    = 3 * M;
  localparam int IDX_W = $clog2(NW + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_CAP   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  function automatic logic signed [9:0] sx8(input logic [7:0] b);
    return {{2{b[7]}}, b};
  endfunction

  function automatic logic signed [ACC_W:0] sxp(input logic [19:0] p);
    return {{(ACC_W - 19){p[19]}}, p};
  endfunction

  // Weight store and transformed weights
  logic signed [7:0]  g_q [NW];
  logic [IDX_W-1:0]   widx_q;
  logic               w_loaded_q;
  logic               u_pend_q;
  logic signed [9:0]  u_d [M][4];
  logic signed [9:0]  u_q [M][4];

  // Control
  state_t             state_q;
  logic               rd_req_q;
  logic               busy_q;
  logic               done_q;
  logic [COL_W-1:0]   col_q;

  // Pipeline
  logic [M*32-1:0]    win_q;
  logic [COL_W-1:0]   col1_q, col2_q, col3_q;
  logic               vld1_q, vld2_q, vld3_q;
  logic signed [9:0]  v_d [M][4];
  logic signed [9:0]  v_q [M][4];
  logic signed [19:0] p_d [M][4];
  logic signed [19:0] p_q [M][4];
  logic signed [ACC_W-1:0] y0_d, y1_d;
  logic signed [ACC_W-1:0] y0_q, y1_q;
  logic [COL_W-1:0]   ocol_q;
  logic               ovld_q;

  // Sequential weight loading in IDLE; U is latched the cycle after the last slot lands
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      widx_q     <= '0;
      w_loaded_q <= 1'b0;
      u_pend_q   <= 1'b0;
      for (int i = 0; i < NW; i++) g_q[i] <= '0;
      for (int r = 0; r < M; r++)
        for (int k = 0; k < 4; k++) u_q[r][k] <= '0;
    end else begin
      u_pend_q <= 1'b0;
      if (i_w_valid && state_q == S_IDLE && !w_loaded_q) begin
        g_q[widx_q] <= i_w_data;
        if (widx_q == IDX_W'(NW - 1)) begin
          w_loaded_q <= 1'b1;
          u_pend_q   <= 1'b1;
        end else begin
          widx_q <= widx_q + IDX_W'(1);
        end
      end
      if (u_pend_q) begin
        for (int r = 0; r < M; r++)
          for (int k = 0; k < 4; k++) u_q[r][k] <= u_d[r][k];
      end
    end
  end

  // Per-row transforms: input transform from the captured window, doubled
  // weight transform, and element-wise products
  for (genvar r = 0; r < M; r++) begin : g_row
    logic [7:0]        d [4];
    logic signed [9:0] g0, g1, g2;

    for (genvar j = 0; j < 4; j++) begin : g_pix
      assign d[j] = win_q[(M-1-r)*32 + (3-j)*8 +: 8];
    end

    assign v_d[r][0] = $signed({2'b00, d[0]}) - $signed({2'b00, d[2]});
    assign v_d[r][1] = $signed({2'b00, d[1]}) + $signed({2'b00, d[2]});
    assign v_d[r][2] = $signed({2'b00, d[2]}) - $signed({2'b00, d[1]});
    assign v_d[r][3] = $signed({2'b00, d[1]}) - $signed({2'b00, d[3]});

    assign g0 = sx8(g_q[3*r]);
    assign g1 = sx8(g_q[3*r+1]);
    assign g2 = sx8(g_q[3*r+2]);

    assign u_d[r][0] = g0 <<< 1;
    assign u_d[r][1] = g0 + g1 + g2;
    assign u_d[r][2] = g0 - g1 + g2;
    assign u_d[r][3] = g2 <<< 1;

    for (genvar k = 0; k < 4; k++) begin : g_mul
      assign p_d[r][k] = $signed({{10{v_q[r][k][9]}}, v_q[r][k]})
                       * $signed({{10{u_q[r][k][9]}}, u_q[r][k]});
    end
  end

  // Control FSM: alternates REQ/CAP, captures the window at CAP, drains the pipe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      rd_req_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      col_q    <= '0;
      col1_q   <= '0;
      vld1_q   <= 1'b0;
      win_q    <= '0;
    end else begin
      rd_req_q <= 1'b0;
      done_q   <= 1'b0;
      vld1_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start && w_loaded_q) begin
            state_q  <= S_REQ;
            rd_req_q <= 1'b1;
            busy_q   <= 1'b1;
            col_q    <= '0;
          end
        end
        S_REQ: begin
          state_q <= S_CAP;
        end
        S_CAP: begin
          win_q  <= lb.i_window;
          col1_q <= col_q;
          vld1_q <= 1'b1;
          col_q  <= col_q + COL_W'(2);
          if (lb.i_finish_reading) begin
            state_q <= S_DRAIN;
          end else begin
            state_q  <= S_REQ;
            rd_req_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!vld1_q && !vld2_q && !vld3_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stages E+1 (V) and E+2 (P)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld2_q <= 1'b0;
      vld3_q <= 1'b0;
      col2_q <= '0;
      col3_q <= '0;
    end else begin
      vld2_q <= vld1_q;
      vld3_q <= vld2_q;
      col2_q <= col1_q;
      col3_q <= col2_q;
      for (int r = 0; r < M; r++) begin
        for (int k = 0; k < 4; k++) begin
          v_q[r][k] <= v_d[r][k];
          p_q[r][k] <= p_d[r][k];
        end
      end
    end
  end

  // Row sum of doubled results, halved (sum is always even) and optionally clamped
  always_comb begin
    logic signed [ACC_W:0] s0;
    logic signed [ACC_W:0] s1;
    s0 = '0;
    s1 = '0;
    for (int r = 0; r < M; r++) begin
      s0 = s0 + sxp(p_q[r][0]) + sxp(p_q[r][1]) + sxp(p_q[r][2]);
      s1 = s1 + sxp(p_q[r][1]) - sxp(p_q[r][2]) - sxp(p_q[r][3]);
    end
    y0_d = s0[ACC_W:1];
    y1_d = s1[ACC_W:1];
`ifdef WINOGRAD_RELU_EN
    if (y0_d[ACC_W-1]) y0_d = '0;
    if (y1_d[ACC_W-1]) y1_d = '0;
`endif
  end

  // Stage E+3: output register, holds value between valid beats
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      y0_q   <= '0;
      y1_q   <= '0;
      ocol_q <= '0;
      ovld_q <= 1'b0;
    end else begin
      ovld_q <= vld3_q;
      if (vld3_q) begin
        y0_q   <= y0_d;
        y1_q   <= y1_d;
        ocol_q <= col3_q;
      end
    end
  end

  assign lb.o_rd_req = rd_req_q;
  assign o_w_loaded  = w_loaded_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_valid     = ovld_q;
  assign o_y0        = y0_q;
  assign o_y1        = y1_q;
  assign o_col       = ocol_q;

endmodule
`default_nettype wire

// File: doc/winograd_f23_conv.md
Name: winograd_f23_conv

Overview:
- Consumer stage directly downstream of the line buffer.
- Pulls M-row by 4-column windows with a request/capture handshake.
- Computes a 3x3-per-row convolution using 1-D Winograd F(2,3) on each row, then sums across the M rows.
- Emits 2 adjacent output pixels per window; the line buffer stride is 2, so successive windows tile the row with no gaps.

Parameters:
M, 3, number of rows in each window; must match the line buffer M
W, 10, row width in pixels; used only to size o_col
ACC_W, 24, width of the signed outputs; must be >= 22+clog2(M)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_w_valid  in  1  weight write strobe
i_w_data  in  8  signed weight
o_w_loaded  out  1  all 3*M weights are present
i_start  in  1  begin a pass over the buffered rows
i_window  in  M*32  window from the line buffer; row 0 in the MSBs; column 0 is the MSB byte of each row (row r, col j at bit ((M-1-r)*32+(3-j)*8))
o_rd_req  out  1  to output_needs_to_be_read
i_finish_reading  in  1  from the line buffer finish_reading
o_y0  out  ACC_W  signed output pixel at column o_col
o_y1  out  ACC_W  signed output pixel at column o_col+1
o_col  out  clog2(W)  column of o_y0
o_valid  out  1  o_y0/o_y1/o_col are valid this cycle
o_busy  out  1  FSM not in IDLE
o_done  out  1  one-cycle pulse at the end of a pass

Behaviour:
- Reset: all outputs 0; weights cleared; weight index 0; FSM to IDLE; pipeline valid bits cleared. Reset mid-pass aborts immediately with no further o_valid or o_done.
- Weight load (IDLE only):
  - Each i_w_valid writes i_w_data to the next slot, order g[r][0..2] for r = 0..M-1.
  - After slot 3M-1 is written, o_w_loaded goes 1 and further writes are ignored until reset.
  - Writes outside IDLE are ignored.
- FSM states:
  - IDLE: on i_start && o_w_loaded, go to REQ and set col = 0. i_start is ignored otherwise, including while busy.
  - REQ: o_rd_req = 1 for exactly this cycle; next state CAP.
  - CAP: sample i_window into stage-1 (edge E); col += 2 for the next window. If i_finish_reading = 1 in this cycle, go to DRAIN; else go to REQ.
  - DRAIN: wait until all pipeline valid bits are 0, pulse o_done, go to IDLE. Weights are retained.
- Request rate: one request every 2 cycles; o_rd_req is never high on two consecutive cycles.
- Arithmetic, per row. Pixels d0..d3 are unsigned 8-bit; weights are signed 8-bit.
  - Input transform: V = [d0-d2, d1+d2, d2-d1, d1-d3], 10-bit signed.
  - Weight transform, doubled to stay integer: U = [2g0, g0+g1+g2, g0-g1+g2, 2g2], 10-bit signed. U is precomputed once when loading completes.
  - Products: P = V*U element-wise, 20-bit signed.
  - Row outputs: Y0r = P0+P1+P2 and Y1r = P1-P2-P3.
  - Output: sum over the M rows, then arithmetic shift right by 1. The shift is exact because the sum is always even. Sign-extend to ACC_W.
- Pipeline, with capture at edge E:
  - E+1: V registered.
  - E+2: P registered.
  - E+3: o_y0, o_y1, o_col registered.
  - o_valid is high for exactly the one cycle after E+3.
  - Outputs hold their value while o_valid = 0.
- o_busy = 1 in REQ, CAP and DRAIN.

Optional Feature:
- Macro: WINOGRAD_RELU_EN.
- When defined, negative o_y0/o_y1 are replaced by 0 at the E+3 register, with no added latency.
- When undefined, outputs are the full signed result.

Test Plan:
- Load all 9 weights = 1, with row r col c holding 10r+c (W=10) and the line buffer asserting finish on its 4th window. Start -> exactly 4 o_valid, with (o_col, o_y0, o_y1) = (0,99,108), (2,117,126), (4,135,144), (6,153,162). Then o_done, and o_busy drops.
- Weights [1,0,-1] on every row, same data -> every o_y0 = o_y1 = -6. With WINOGRAD_RELU_EN -> all 0.
- All weights = -128, all pixels = 255 -> o_y0 = o_y1 = -293760. Checks sign extension with no overflow at ACC_W = 24.
- i_start with only 8 weights loaded -> o_rd_req stays 0 and o_busy stays 0. Load the 9th weight, then i_start -> first o_rd_req on the cycle after the start edge.
- i_finish_reading high on the first CAP -> exactly one o_valid, then o_done. A second i_start issued during DRAIN is ignored.
- i_rst asserted one cycle after the second CAP -> no o_valid afterwards, all outputs 0, o_w_loaded = 0, and i_start is ignored until the weights are reloaded.
